// File: rtl/ofifo_pkg.sv
// Shared constants for the output FIFO behind the MAC array.
// Optional feature macro: OFIFO_OVF_ERR_EN (sticky overflow/underflow flag).
package ofifo_pkg;

    localparam int PSUM_BW     = 16;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 64;

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int ptr_width(input int depth_entries);
        return $clog2(depth_entries) + 1;
    endfunction

    localparam int OFIFO_PTR_W = ptr_width(OFIFO_DEPTH);

endpackage

// File: rtl/ofifo_fifo_lane.sv
// One column lane of the output FIFO: storage, write pointer and full/empty
// status. The read address comes from the shared row read pointer.
module fifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH,
    localparam int pw     = ptr_width(depth),
    localparam int aw     = pw - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic [pw-1:0]      rptr,
    output logic [psum_bw-1:0] dout,
    output logic               full,
    output logic               empty
);

    logic [pw-1:0]      wptr;
    logic [psum_bw-1:0] mem [depth];
    logic               wr_ok;

    // Status from pointers only; the wrap bit separates full from empty.
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
        wr_ok = wr && !full;
        dout  = mem[rptr[aw-1:0]];
    end

    // Write pointer advances only on an accepted write; writes to a full lane are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
        end else if (wr_ok) begin
            wptr <= wptr + 1'b1;
        end
    end

    // Storage has no reset; contents past the pointers are never observed.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wptr[aw-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO: re-aligns skewed per-column partial sums into full rows and
// hands rows out through a registered read with a one-cycle out_vld pulse.
// Optional feature macro: OFIFO_OVF_ERR_EN adds a sticky err output.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = OFIFO_DEPTH,
    localparam int pw     = ptr_width(depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_vld
`ifdef OFIFO_OVF_ERR_EN
    ,
    output logic                   err
`endif
);

    logic [pw-1:0]          rptr;
    logic [col-1:0]         full_v;
    logic [col-1:0]         empty_v;
    logic [psum_bw-1:0]     lane_dout [col];
    logic [psum_bw*col-1:0] row;
    logic                   rd_acc;

    for (genvar c = 0; c < col; c++) begin : g_lane
        fifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .din   (in[psum_bw*c +: psum_bw]),
            .wr    (wr[c]),
            .rptr  (rptr),
            .dout  (lane_dout[c]),
            .full  (full_v[c]),
            .empty (empty_v[c])
        );
        assign row[psum_bw*c +: psum_bw] = lane_dout[c];
    end

    // A row exists only once every lane holds data; any full lane blocks the array.
    always_comb begin
        o_valid = ~|empty_v;
        o_full  = |full_v;
        o_ready = ~o_full;
        rd_acc  = rd && o_valid;
    end

    // Shared read pointer and registered row output; reads without a full row are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr    <= '0;
            out     <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= rd_acc;
            if (rd_acc) begin
                out  <= row;
                rptr <= rptr + 1'b1;
            end
        end
    end

`ifdef OFIFO_OVF_ERR_EN
    // Sticky error on any dropped write or ignored read; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((|(wr & full_v)) || (rd && !o_valid)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: table-driven skew test, hand sequences for
// fill/underflow/streaming/reset, and a randomized run against a queue model.
module tb_ofifo;

    localparam int BW = 16;
    localparam int NC = 8;
    localparam int DP = 64;
    localparam int W  = BW * NC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in = '0;
    logic [NC-1:0] wr = '0;
    logic          rd = 1'b0;
    logic          o_full, o_ready, o_valid, out_vld;
    logic [W-1:0]  out;
`ifdef OFIFO_OVF_ERR_EN
    logic          err;
`endif

    ofifo #(.psum_bw(BW), .col(NC), .depth(DP)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .out     (out),
        .out_vld (out_vld)
`ifdef OFIFO_OVF_ERR_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: one queue per lane, rows popped together.
    logic [BW-1:0] mq [NC][$];
    logic [W-1:0]  m_out;
    logic          m_vld;
    logic          m_err;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic model_valid();
        for (int c = 0; c < NC; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_full();
        for (int c = 0; c < NC; c++) if (mq[c].size() == DP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("o_valid", W'(o_valid), W'(model_valid()));
        check("o_full",  W'(o_full),  W'(model_full()));
        check("o_ready", W'(o_ready), W'(!model_full()));
        check("out_vld", W'(out_vld), W'(m_vld));
        check("out",     out,         m_out);
`ifdef OFIFO_OVF_ERR_EN
        check("err",     W'(err),     W'(m_err));
`endif
    endtask

    // Drive one cycle, advance the model by the same rules, then compare after the edge.
    task automatic applyStimulus(input logic r_st, input logic [NC-1:0] w,
                                 input logic [W-1:0] d, input logic r);
        int  pre_size [NC];
        logic pre_valid;
        reset = r_st; wr = w; in = d; rd = r;
        for (int c = 0; c < NC; c++) pre_size[c] = mq[c].size();
        pre_valid = model_valid();
        if (r_st) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_out = '0; m_vld = 1'b0; m_err = 1'b0;
        end else begin
            if (r && !pre_valid) m_err = 1'b1;
            m_vld = r && pre_valid;
            if (m_vld) begin
                for (int c = 0; c < NC; c++) m_out[BW*c +: BW] = mq[c].pop_front();
            end
            for (int c = 0; c < NC; c++) begin
                if (w[c]) begin
                    if (pre_size[c] < DP) mq[c].push_back(d[BW*c +: BW]);
                    else m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic logic [W-1:0] make_row(input int base, input int mul);
        logic [W-1:0] r;
        for (int c = 0; c < NC; c++) r[BW*c +: BW] = BW'(base * mul + c);
        return r;
    endfunction

    typedef struct {
        logic [NC-1:0] wr;
        logic          rd;
        logic          exp_valid;
        logic          exp_full;
        logic          exp_vld;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [W-1:0] skew_data;
        logic [W-1:0] skew_row;
        logic [W-1:0] rnd;
        int next_k;
        int fulls;

        m_out = '0; m_vld = 1'b0; m_err = 1'b0;
        skew_data = make_row(0, 0) + make_row(16'h0100, 0) ;
        for (int c = 0; c < NC; c++) skew_data[BW*c +: BW] = BW'(16'h0100 + c);
        skew_row = skew_data;

        // Reset then idle
        $display("[TB] reset and idle");
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        check("idle_out",     out,          '0);
        check("idle_valid",   W'(o_valid),  W'(0));
        check("idle_ready",   W'(o_ready),  W'(1));
        check("idle_full",    W'(o_full),   W'(0));
        check("idle_out_vld", W'(out_vld),  W'(0));

        // Skewed write pattern as a vector table
        $display("[TB] skewed write table");
        for (int i = 0; i < 7; i++) vecs[i] = '{NC'((2 << i) - 1), 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, vecs[i].wr, skew_data, vecs[i].rd);
            check("tbl_valid", W'(o_valid), W'(vecs[i].exp_valid));
            check("tbl_full",  W'(o_full),  W'(vecs[i].exp_full));
            check("tbl_vld",   W'(out_vld), W'(vecs[i].exp_vld));
            if (i >= 8) check("tbl_row", out, skew_row);
        end

        // Fill lane 0 to full, overflow once, then fill others and drain
        $display("[TB] fill lane 0");
        applyStimulus(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < DP; k++) applyStimulus(1'b0, 8'h01, W'(k + 16'h0500), 1'b0);
        check("fill_full",  W'(o_full),  W'(1));
        check("fill_ready", W'(o_ready), W'(0));
        check("fill_valid", W'(o_valid), W'(0));
        applyStimulus(1'b0, 8'h01, W'(16'hDEAD), 1'b0);
`ifdef OFIFO_OVF_ERR_EN
        check("ovf_err", W'(err), W'(1));
`endif
        for (int k = 0; k < DP; k++) applyStimulus(1'b0, 8'hFE, make_row(k, 8), 1'b0);
        for (int k = 0; k < DP; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            check("drain_lane0", W'(out[BW-1:0]), W'(k + 16'h0500));
        end
        check("drain_empty", W'(o_valid), W'(0));

        // Underflow on an empty FIFO
        $display("[TB] underflow");
        applyStimulus(1'b1, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        check("unf_vld", W'(out_vld), W'(0));
        check("unf_out", out, '0);
`ifdef OFIFO_OVF_ERR_EN
        check("unf_err", W'(err), W'(1));
`endif

        // Streaming 128 rows across pointer wrap with rd whenever a row exists
        $display("[TB] streaming");
        applyStimulus(1'b1, '0, '0, 1'b0);
        next_k = 0;
        fulls  = 0;
        for (int k = 0; k < 131; k++) begin
            applyStimulus(1'b0, (k < 128) ? 8'hFF : 8'h00,
                          (k < 128) ? make_row(k, 16) : '0, model_valid());
            if (o_full) fulls++;
            if (out_vld) begin
                check("stream_row", out, make_row(next_k, 16));
                next_k++;
            end
        end
        check("stream_count", W'(next_k), W'(128));
        check("stream_nofull", W'(fulls), W'(0));

        // Reset mid-stream with rows stored and a read pending
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 8'hFF, make_row(k, 16), 1'b0);
        applyStimulus(1'b1, 8'hFF, make_row(77, 16), 1'b1);
        check("rst_valid", W'(o_valid), W'(0));
        check("rst_out",   out,         '0);
        check("rst_vld",   W'(out_vld), W'(0));
        applyStimulus(1'b0, 8'hFF, make_row(16'hAAA, 16), 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        check("rst_first_row", out, make_row(16'hAAA, 16));

        // Randomized traffic against the model
        $display("[TB] random traffic");
        applyStimulus(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b0, NC'($urandom), rnd, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
